// File: rtl/feedback_scheduler_if.sv
// Sample handshake plus clause-memory / feedback control bundle for feedback_scheduler.
// master is the scheduler side; slave is the sample source, memory and feedback datapath.
interface feedback_scheduler_if #(
    parameter int unsigned GROUP_IDX_WIDTH = 2
);
    logic                       sample_valid;
    logic                       sample_label;
    logic                       sample_ready;
    logic [GROUP_IDX_WIDTH-1:0] group_idx;
    logic                       mem_rd_en;
    logic                       mem_rd_valid;
    logic                       fb_en;
    logic                       fb_is_positive;
    logic                       fb_type3_en;
    logic                       mem_wr_en;
    logic                       sample_done;

    modport master (
        input  sample_valid, sample_label, mem_rd_valid,
        output sample_ready, group_idx, mem_rd_en, fb_en, fb_is_positive, fb_type3_en,
               mem_wr_en, sample_done
    );

    modport slave (
        output sample_valid, sample_label, mem_rd_valid,
        input  sample_ready, group_idx, mem_rd_en, fb_en, fb_is_positive, fb_type3_en,
               mem_wr_en, sample_done
    );
endinterface

// File: rtl/feedback_scheduler.sv
// Per-sample training sequencer: walks clause groups (read, wait, feedback, writeback)
// and decides Type III activation per sample from a Galois LFSR.
module feedback_scheduler #(
    parameter int unsigned             CLAUSE_GROUPS   = 4,
    parameter int unsigned             GROUP_IDX_WIDTH = 2,
    parameter int unsigned             LFSR_WIDTH      = 24,
    parameter logic [LFSR_WIDTH-1:0]   LFSR_SEED       = 24'hACE15A,
    parameter int unsigned             T3_MASK_BITS    = 2,
    parameter int unsigned             COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   train_en,
    input  logic                   t3_cfg_en,
    feedback_scheduler_if.master   bus,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] sample_count
);
    // Right-shifting Galois form of x^24 + x^23 + x^22 + x^17 + 1
    localparam logic [LFSR_WIDTH-1:0] LfsrTaps = LFSR_WIDTH'(24'hE10000);
    localparam logic [GROUP_IDX_WIDTH-1:0] LastGroup = GROUP_IDX_WIDTH'(CLAUSE_GROUPS - 1);

    typedef enum logic [2:0] {StIdle, StRd, StWait, StFb, StWb, StDone} state_e;

    state_e                     state_q, state_d;
    logic [GROUP_IDX_WIDTH-1:0] group_q, group_d;
    logic [LFSR_WIDTH-1:0]      lfsr_q, lfsr_next;
    logic                       pos_q, t3_q;
    logic [COUNT_WIDTH-1:0]     count_q;
    logic                       accept;
    logic                       ready, rd_en, fb_en, wr_en, done;

    assign accept    = (state_q == StIdle) && train_en && bus.sample_valid;
    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            group_q <= '0;
            lfsr_q  <= LFSR_SEED;
            pos_q   <= 1'b0;
            t3_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            group_q <= group_d;
            if (accept) begin
                // Type III decision uses the LFSR value before this step
                pos_q  <= bus.sample_label;
                t3_q   <= t3_cfg_en && !bus.sample_label &&
                          (lfsr_q[T3_MASK_BITS-1:0] == '0);
                lfsr_q <= lfsr_next;
            end
            if (state_q == StDone) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        group_d = group_q;
        ready   = 1'b0;
        rd_en   = 1'b0;
        fb_en   = 1'b0;
        wr_en   = 1'b0;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                ready = train_en;
                if (accept) begin
                    state_d = StRd;
                    group_d = '0;
                end
            end
            StRd: begin
                rd_en   = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (bus.mem_rd_valid) begin
                    state_d = StFb;
                end
            end
            StFb: begin
                fb_en   = 1'b1;
                state_d = StWb;
            end
            StWb: begin
                wr_en = 1'b1;
                if (group_q == LastGroup) begin
                    state_d = StDone;
                end else begin
                    group_d = group_q + GROUP_IDX_WIDTH'(1);
                    state_d = StRd;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.sample_ready   = ready;
    assign bus.group_idx      = group_q;
    assign bus.mem_rd_en      = rd_en;
    assign bus.fb_en          = fb_en;
    assign bus.fb_is_positive = pos_q;
    assign bus.fb_type3_en    = t3_q;
    assign bus.mem_wr_en      = wr_en;
    assign bus.sample_done    = done;
    assign busy               = (state_q != StIdle);
    assign sample_count       = count_q;
endmodule

// File: tb/tb_feedback_scheduler.sv
// Directed plus randomized bench for feedback_scheduler; expected per-cycle outputs come
// from a timeline built from the per-group step rules and a software LFSR/count model.
module tb_feedback_scheduler;
    localparam int GW = 2;
    // Narrow counter so the wrap is reachable within a short run
    localparam int CW = 5;
    localparam logic [23:0] SEED = 24'hACE15A;

    logic          clk = 1'b0;
    logic          rst;
    logic          train_en;
    logic          t3_cfg_en;
    logic          busy;
    logic [CW-1:0] sample_count;

    feedback_scheduler_if #(.GROUP_IDX_WIDTH(GW)) bus ();

    feedback_scheduler #(
        .CLAUSE_GROUPS(4), .GROUP_IDX_WIDTH(GW), .LFSR_WIDTH(24), .LFSR_SEED(SEED),
        .T3_MASK_BITS(2), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .train_en(train_en), .t3_cfg_en(t3_cfg_en), .bus(bus),
        .busy(busy), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rd;
        logic          fb;
        logic          wr;
        logic          done;
        logic [GW-1:0] grp;
        logic          vld;
    } step_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned m_count = 0;
    logic [23:0] m_lfsr = SEED;
    int          wraps = 0;

    function automatic logic [23:0] lfsr_step(input logic [23:0] v);
        logic [23:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 24'hE10000;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full sample from IDLE back to IDLE; dN = WAIT cycles for group N (1 = next-cycle read)
    task automatic run_sample(input bit label, input bit t3, input int d0, input int d1,
                              input int d2, input int d3, input bit hold_valid,
                              input int drop_grp, input bit noise, input int exp_lat);
        step_t q[$];
        int    dly[4];
        int    lat;
        bit    exp_pos, exp_t3;
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        bus.sample_valid = 1'b1;
        bus.sample_label = label;
        t3_cfg_en        = t3;
        #1;
        check("ready_before_accept", 32'(bus.sample_ready), 32'd1);
        exp_pos = label;
        exp_t3  = t3 && !label && (m_lfsr[1:0] == 2'b00);
        m_lfsr  = lfsr_step(m_lfsr);
        for (int g = 0; g < 4; g++) begin
            q.push_back('{rd: 1'b1, fb: 1'b0, wr: 1'b0, done: 1'b0, grp: GW'(g), vld: 1'b0});
            for (int w = 1; w <= dly[g]; w++)
                q.push_back('{rd: 1'b0, fb: 1'b0, wr: 1'b0, done: 1'b0, grp: GW'(g),
                              vld: (w == dly[g])});
            q.push_back('{rd: 1'b0, fb: 1'b1, wr: 1'b0, done: 1'b0, grp: GW'(g), vld: 1'b0});
            q.push_back('{rd: 1'b0, fb: 1'b0, wr: 1'b1, done: 1'b0, grp: GW'(g), vld: 1'b0});
        end
        q.push_back('{rd: 1'b0, fb: 1'b0, wr: 1'b0, done: 1'b1, grp: GW'(3), vld: 1'b0});
        tick();
        if (!hold_valid) bus.sample_valid = 1'b0;
        // Controls were latched; scrambling them now must not matter
        bus.sample_label = 1'($urandom);
        t3_cfg_en        = 1'($urandom);
        lat = 0;
        foreach (q[i]) begin
            step_t s;
            bit    waiting;
            s = q[i];
            waiting = !(s.rd || s.fb || s.wr || s.done);
            bus.mem_rd_valid = s.vld | (noise && !waiting && 1'($urandom));
            if (s.rd && drop_grp == int'(s.grp)) train_en = 1'b0;
            #1;
            lat++;
            check("cycle_outputs",
                  32'({bus.mem_rd_en, bus.fb_en, bus.mem_wr_en, bus.sample_done,
                       bus.group_idx, busy, bus.sample_ready, bus.fb_is_positive,
                       bus.fb_type3_en}),
                  32'({s.rd, s.fb, s.wr, s.done, s.grp, 1'b1, 1'b0, exp_pos, exp_t3}));
            if (s.done && exp_lat > 0) check("done_latency", 32'(lat), 32'(exp_lat));
            tick();
        end
        bus.mem_rd_valid = 1'b0;
        m_count = (m_count + 1) % (1 << CW);
        if (m_count == 0) wraps++;
        check("count_after_done", 32'(sample_count), 32'(m_count));
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int hits;
        int start_cnt;
        rst = 1'b1; train_en = 1'b0; t3_cfg_en = 1'b0;
        bus.sample_valid = 1'b0; bus.sample_label = 1'b0; bus.mem_rd_valid = 1'b0;
        tick(); tick();
        check("reset_outputs",
              32'({bus.mem_rd_en, bus.fb_en, bus.mem_wr_en, bus.sample_done, bus.group_idx,
                   busy, bus.sample_ready, bus.fb_is_positive, bus.fb_type3_en}), 32'd0);
        check("reset_count", 32'(sample_count), 32'd0);
        rst = 1'b0;
        tick();
        train_en = 1'b1;
        #1;
        check("ready_follows_train_en", 32'(bus.sample_ready), 32'd1);

        // Positive sample, 1-cycle reads
        run_sample(1'b1, 1'b1, 1, 1, 1, 1, 1'b0, -1, 1'b0, 17);
        tick();

        // Negative samples with Type III allowed until the LFSR low bits hit zero
        hits = 0;
        for (int i = 0; i < 16 && hits == 0; i++) begin
            if (m_lfsr[1:0] == 2'b00) hits++;
            run_sample(1'b0, 1'b1, 1, 1, 1, 1, 1'b0, -1, 1'b0, 17);
        end
        check("t3_hit_reached", 32'(hits), 32'd1);

        // Same condition with Type III globally disabled
        hits = 0;
        for (int i = 0; i < 16 && hits == 0; i++) begin
            if (m_lfsr[1:0] == 2'b00) hits++;
            run_sample(1'b0, (m_lfsr[1:0] != 2'b00), 1, 1, 1, 1, 1'b0, -1, 1'b0, 17);
        end
        check("t3_disabled_reached", 32'(hits), 32'd1);

        // Read for group 2 delayed to 5 cycles
        run_sample(1'b1, 1'b0, 1, 1, 5, 1, 1'b0, -1, 1'b0, 21);

        // Back-to-back with sample_valid held high
        start_cnt = int'(sample_count);
        for (int i = 0; i < 3; i++)
            run_sample(1'($urandom), 1'b1, 1, 1, 1, 1, 1'b1, -1, 1'b0, 17);
        bus.sample_valid = 1'b0;
        check("b2b_three_done", 32'((int'(sample_count) - start_cnt) & ((1 << CW) - 1)), 32'd3);

        // train_en dropped during group 1
        run_sample(1'b0, 1'b1, 1, 1, 1, 1, 1'b0, 1, 1'b0, 17);
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("no_accept_without_train_en", 32'({busy, bus.sample_ready}), 32'd0);
            tick();
        end
        train_en = 1'b1;
        #1;
        check("ready_after_train_en_return", 32'(bus.sample_ready), 32'd1);
        bus.sample_valid = 1'b0;

        // Reset while in FB for group 0
        bus.sample_valid = 1'b1;
        bus.sample_label = 1'b0;
        t3_cfg_en = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        check("rst_seq_rd", 32'(bus.mem_rd_en), 32'd1);
        tick();
        bus.mem_rd_valid = 1'b1;
        tick();
        bus.mem_rd_valid = 1'b0;
        check("rst_seq_fb", 32'(bus.fb_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_fb_outputs",
              32'({bus.mem_rd_en, bus.fb_en, bus.mem_wr_en, bus.sample_done, bus.group_idx,
                   busy, bus.fb_is_positive, bus.fb_type3_en}), 32'd0);
        check("rst_in_fb_count", 32'(sample_count), 32'd0);
        m_count = 0;
        m_lfsr  = SEED;
        tick();
        check("no_writeback_after_rst", 32'({bus.mem_wr_en, busy}), 32'd0);

        // Randomized samples with read jitter and stray mem_rd_valid; crosses the count wrap
        wraps = 0;
        for (int i = 0; i < 40; i++) begin
            run_sample(1'($urandom), 1'($urandom), $urandom_range(1, 3), $urandom_range(1, 3),
                       $urandom_range(1, 3), $urandom_range(1, 3), 1'b0, -1, 1'b1, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        check("count_wrapped", 32'(wraps), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
